// File: rtl/present_pkg.sv
// Shared PRESENT primitives: 4-bit S-box pair, bit permutation pair, FSM state type.
package present_pkg;

  localparam int BLOCK_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
      4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
      4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
      4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
    endcase
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] s_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    for (int i = 0; i < 16; i++) y[6'(4*i) +: 4] = sbox(x[6'(4*i) +: 4]);
    return y;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_s_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    for (int i = 0; i < 16; i++) y[6'(4*i) +: 4] = inv_sbox(x[6'(4*i) +: 4]);
    return y;
  endfunction

  // Bit i moves to 16*i mod 63; bit 63 stays put.
  function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[6'((16*i) % 63)] = x[6'(i)];
    return y;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_p_layer(input logic [BLOCK_SIZE-1:0] x);
    logic [BLOCK_SIZE-1:0] y;
    y[63] = x[63];
    for (int i = 0; i < 63; i++) y[6'(i)] = x[6'((16*i) % 63)];
    return y;
  endfunction

endpackage

// File: rtl/present_key_sched.sv
// PRESENT key register with one forward or inverse key-schedule step per cycle.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [KEY_SIZE-1:0]   load_value,
  input  logic                  step,
  input  logic                  inverse,
  input  logic [4:0]            round_cnt,
  output logic [KEY_SIZE-1:0]   step_value,
  output logic [BLOCK_SIZE-1:0] round_key
);

  if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
    $error("present_key_sched: KEY_SIZE must be 80 or 128");
  end

  localparam int CNT_LSB = (KEY_SIZE == 128) ? 62 : 15;

  logic [KEY_SIZE-1:0] key_reg;
  logic [KEY_SIZE-1:0] fwd;
  logic [KEY_SIZE-1:0] unmixed;

  // NOTE: every variable assigned in always_comb gets a full value before any
  // partial update, so no path leaves it holding a stale value (no latch).
  always_comb begin
    fwd = {key_reg[KEY_SIZE-62:0], key_reg[KEY_SIZE-1:KEY_SIZE-61]};
    fwd[KEY_SIZE-1 -: 4] = sbox(fwd[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) fwd[KEY_SIZE-5 -: 4] = sbox(fwd[KEY_SIZE-5 -: 4]);
    fwd[CNT_LSB +: 5] = fwd[CNT_LSB +: 5] ^ round_cnt;

    // Inverse undoes the counter mix, then the S-boxes, then the rotation.
    unmixed = key_reg;
    unmixed[CNT_LSB +: 5] = unmixed[CNT_LSB +: 5] ^ round_cnt;
    unmixed[KEY_SIZE-1 -: 4] = inv_sbox(unmixed[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) unmixed[KEY_SIZE-5 -: 4] = inv_sbox(unmixed[KEY_SIZE-5 -: 4]);
  end

  assign step_value = inverse ? {unmixed[60:0], unmixed[KEY_SIZE-1:61]} : fwd;
  assign round_key  = key_reg[KEY_SIZE-1 -: BLOCK_SIZE];

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)     key_reg <= '0;
    else if (load) key_reg <= load_value;
    else if (step) key_reg <= step_value;
  end

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT encrypt/decrypt core with a one-entry decryption key cache.
module present_cipher_core
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = 80,
  parameter int NUM_ROUNDS = 31
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] data_out
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: NUM_ROUNDS must be in 1..31");
  end

  // The counter is 5 bits, so for 31 rounds the final add-key index wraps to 0.
  localparam logic [4:0] LAST_CNT  = 5'(NUM_ROUNDS + 1);
  localparam logic [4:0] FINAL_EXP = 5'(NUM_ROUNDS);

  state_t                state;
  logic [4:0]            cnt;
  logic [BLOCK_SIZE-1:0] block;
  logic [BLOCK_SIZE-1:0] round_out;
  logic                  dec;
  logic                  cache_valid;
  logic [KEY_SIZE-1:0]   cache_key;
  logic [KEY_SIZE-1:0]   cache_final;

  logic                  accept;
  logic                  cache_hit;
  logic                  ks_step;
  logic                  ks_inverse;
  logic [4:0]            ks_cnt;
  logic [KEY_SIZE-1:0]   ks_step_value;
  logic [BLOCK_SIZE-1:0] round_key;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign data_out   = block;
  assign accept     = in_valid && in_ready;
  assign cache_hit  = cache_valid && (key == cache_key);
  assign ks_step    = (state == KEYEXP) || (state == ROUND);
  assign ks_inverse = (state == ROUND) && dec;
  assign ks_cnt     = ks_inverse ? cnt - 5'd1 : cnt;

  present_key_sched #(.KEY_SIZE(KEY_SIZE)) u_key_sched (
    .clk        (Clock),
    .reset      (Reset),
    .load       (accept),
    .load_value ((mode && cache_hit) ? cache_final : key),
    .step       (ks_step),
    .inverse    (ks_inverse),
    .round_cnt  (ks_cnt),
    .step_value (ks_step_value),
    .round_key  (round_key)
  );

  // The LAST_CNT cycle is a bare add-key: final whitening on encrypt, initial on decrypt.
  always_comb begin
    round_out = block ^ round_key;
    if (cnt != LAST_CNT)
      round_out = dec ? inv_s_layer(inv_p_layer(block)) ^ round_key
                      : p_layer(s_layer(block ^ round_key));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      block       <= '0;
      dec         <= 1'b0;
      cache_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dec   <= mode;
          block <= data_in;
          if (!mode) begin
            state <= ROUND;
            cnt   <= 5'd1;
          end else if (cache_hit) begin
            state <= ROUND;
            cnt   <= LAST_CNT;
          end else begin
            state       <= KEYEXP;
            cnt         <= 5'd1;
            cache_valid <= 1'b0;
          end
        end
        KEYEXP: if (cnt == FINAL_EXP) begin
          state       <= ROUND;
          cnt         <= LAST_CNT;
          cache_valid <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
        ROUND: begin
          block <= round_out;
          if (dec) begin
            if (cnt == 5'd1) state <= DONE;
            cnt <= cnt - 5'd1;
          end else begin
            if (cnt == LAST_CNT) state <= DONE;
            cnt <= cnt + 5'd1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the cached key and expanded key are plain storage with no reset;
  // cache_valid, which is reset, is the only thing that makes them meaningful.
  always_ff @(posedge Clock) begin
    if (accept && mode && !cache_hit)         cache_key   <= key;
    if (state == KEYEXP && cnt == FINAL_EXP) cache_final <= ks_step_value;
  end

endmodule

// File: tb/tb_present_cipher_core.sv
// Scoreboard bench for present_cipher_core at KEY_SIZE 80 and 128 against a behavioural PRESENT model.
module tb_present_cipher_core;

  localparam int NR = 31;
  localparam logic [3:0] SBOX_T [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic         clk;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic         mode;
  logic         out_ready;
  logic [127:0] key;
  logic [63:0]  data_in;

  logic         in_ready80, out_valid80, in_ready128, out_valid128;
  logic [63:0]  data_out80, data_out128;
  logic         in_ready_s, out_valid_s;
  logic [63:0]  data_out_s;

  present_cipher_core #(.KEY_SIZE(80), .NUM_ROUNDS(NR)) dut80 (
    .Clock(clk), .Reset(rst), .in_valid(in_valid && !sel), .in_ready(in_ready80),
    .mode(mode), .key(key[79:0]), .data_in(data_in), .out_valid(out_valid80),
    .out_ready(out_ready && !sel), .data_out(data_out80));

  present_cipher_core #(.KEY_SIZE(128), .NUM_ROUNDS(NR)) dut128 (
    .Clock(clk), .Reset(rst), .in_valid(in_valid && sel), .in_ready(in_ready128),
    .mode(mode), .key(key), .data_in(data_in), .out_valid(out_valid128),
    .out_ready(out_ready && sel), .data_out(data_out128));

  assign in_ready_s  = sel ? in_ready128  : in_ready80;
  assign out_valid_s = sel ? out_valid128 : out_valid80;
  assign data_out_s  = sel ? data_out128  : data_out80;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    string       name;
    logic [63:0] data;
    int          lat;
    longint      accept;
    int          hold;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           mon_busy = 1'b0;
  bit           cv[2];
  logic [127:0] ck[2];
  logic [127:0] pool[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, wanted %h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [63:0] ref_sub(input logic [63:0] s, input bit invert);
    logic [63:0] r;
    logic [3:0]  v;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      v = s[4*j +: 4];
      if (!invert) r[4*j +: 4] = SBOX_T[v];
      else for (int x = 0; x < 16; x++) if (SBOX_T[x] == v) r[4*j +: 4] = 4'(x);
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] s, input bit invert);
    logic [63:0] r;
    int p;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (!invert) r[p] = s[i];
      else         r[i] = s[p];
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_key_next(input logic [127:0] k, input int n, input int c);
    logic [127:0] r;
    int pos;
    r = '0;
    for (int i = 0; i < n; i++) r[(i + 61) % n] = k[i];
    r[n-1 -: 4] = SBOX_T[r[n-1 -: 4]];
    if (n == 128) r[n-5 -: 4] = SBOX_T[r[n-5 -: 4]];
    pos = (n == 80) ? 15 : 62;
    r[pos +: 5] = r[pos +: 5] ^ 5'(c);
    return r;
  endfunction

  function automatic logic [63:0] ref_cipher(input logic m, input logic [127:0] k0,
                                             input logic [63:0] d, input int n);
    logic [127:0] k;
    logic [63:0]  rks [0:32];
    logic [63:0]  s;
    k = k0;
    for (int i = 1; i <= NR + 1; i++) begin
      rks[i] = k[n-1 -: 64];
      if (i <= NR) k = ref_key_next(k, n, i);
    end
    if (!m) begin
      s = d;
      for (int r = 1; r <= NR; r++) s = ref_perm(ref_sub(s ^ rks[r], 1'b0), 1'b0);
      s = s ^ rks[NR+1];
    end else begin
      s = d ^ rks[NR+1];
      for (int r = NR; r >= 1; r--) s = ref_sub(ref_perm(s, 1'b1), 1'b1) ^ rks[r];
    end
    return s;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic m, input logic [127:0] k, input logic [63:0] d,
                       input logic [63:0] exp, input int hold, input string name);
    logic [127:0] kk;
    int lat;
    int w;
    kk = sel ? k : {48'b0, k[79:0]};
    w = 0;
    @(negedge clk);
    while (!in_ready_s && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready_s) begin
      bound_fail({name, "_accept"});
      return;
    end
    mode = m; key = kk; data_in = d; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!m) lat = NR + 1;
    else if (cv[sel] && ck[sel] == kk) lat = NR + 1;
    else begin
      lat = 2 * NR + 1;
      cv[sel] = 1'b1;
      ck[sel] = kk;
    end
    sb.push_back('{name, exp, lat, cycle, hold});
    // Junk on the inputs while busy must have no effect.
    repeat (4) begin
      mode = 1'($urandom);
      key = {$urandom, $urandom, $urandom, $urandom};
      data_in = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic m, input logic [127:0] k, input logic [63:0] d,
                             input string name);
    logic [127:0] kk;
    kk = sel ? k : {48'b0, k[79:0]};
    issue(m, kk, d, ref_cipher(m, kk, d, sel ? 128 : 80), 0, name);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while ((sb.size() != 0 || mon_busy || !in_ready_s) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) bound_fail(name);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t        it;
    logic [63:0] held;
    bit          stable;
    int          hold;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_s) begin
        mon_busy = 1'b1;
        hold = 0;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %h with no request pending", data_out_s);
        end else begin
          it = sb.pop_front();
          hold = it.hold;
          check({it.name, "_data"}, data_out_s, it.data);
          check({it.name, "_latency"}, 64'(cycle - it.accept), 64'(it.lat));
        end
        held = data_out_s;
        stable = 1'b1;
        repeat (hold) begin
          @(negedge clk);
          if (!out_valid_s || data_out_s !== held || in_ready_s) stable = 1'b0;
        end
        if (hold > 0) check({it.name, "_stall_stable"}, 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_ready_valid", 64'({in_ready_s, out_valid_s}), 64'b10);
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; mode = 1'b0; key = '0; data_in = '0;
    cv[0] = 1'b0; cv[1] = 1'b0; ck[0] = '0; ck[1] = '0;
    pool[0] = '0;
    pool[1] = {$urandom, $urandom, $urandom, $urandom};
    pool[2] = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready80", 64'(in_ready80), 64'd1);
    check("reset_out_valid80", 64'(out_valid80), 64'd0);
    check("reset_data_out80", data_out80, 64'd0);
    check("reset_in_ready128", 64'(in_ready128), 64'd1);
    check("reset_out_valid128", 64'(out_valid128), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // KEY_SIZE = 80 directed vectors
    issue(1'b0, '0, 64'h0, 64'h5579C1387B228445, 0, "enc80_zero");
    issue(1'b1, '0, 64'h5579C1387B228445, 64'h0, 0, "dec80_zero_miss");
    issue(1'b1, '0, 64'h5579C1387B228445, 64'h0, 0, "dec80_zero_hit");
    issue_model(1'b1, {128{1'b1}}, {$urandom, $urandom}, "dec80_ones_prime");
    issue(1'b0, {128{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2, 10, "enc80_ones_stall");
    issue(1'b1, {128{1'b1}}, 64'h3333DCD3213210D2, {64{1'b1}}, 0, "dec80_ones_hit");

    for (int i = 0; i < 12; i++)
      issue_model(1'($urandom_range(0, 1)), pool[$urandom_range(0, 2)],
                  {$urandom, $urandom}, "rand80");

    // Reset in the middle of a cache-hit decrypt, then the same key must miss.
    issue_model(1'b1, pool[1], {$urandom, $urandom}, "dec80_prime_abort");
    issue_model(1'b1, pool[1], {$urandom, $urandom}, "dec80_aborted");
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 64'(in_ready_s), 64'd1);
    check("abort_out_valid", 64'(out_valid_s), 64'd0);
    check("abort_data_out", data_out_s, 64'd0);
    sb.delete();
    cv[0] = 1'b0; cv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue_model(1'b1, pool[1], {$urandom, $urandom}, "dec80_after_abort");
    wait_idle("drain80");

    // KEY_SIZE = 128
    sel = 1'b1;
    issue(1'b0, '0, 64'h0, 64'h96DB702A2E6900AF, 0, "enc128_zero");
    issue(1'b1, '0, 64'h96DB702A2E6900AF, 64'h0, 0, "dec128_zero_miss");
    for (int i = 0; i < 6; i++)
      issue_model(1'($urandom_range(0, 1)), pool[$urandom_range(0, 2)],
                  {$urandom, $urandom}, "rand128");
    wait_idle("drain128");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/present_cipher_core.md
PRESENT_CIPHER_CORE -- requirements
Module: present_cipher_core

Interface
REQ-001 The block SHALL have parameter KEY_SIZE, default 80, giving the key width; legal values are 80 and 128 only.
REQ-002 The block SHALL have parameter NUM_ROUNDS, default 31, giving the count of full rounds (add-key, S-layer, P-layer).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled on acceptance.
REQ-008 The block SHALL have port key, input, KEY_SIZE bits: the user key; sampled on acceptance.
REQ-009 The block SHALL have port data_in, input, 64 bits: the plaintext or ciphertext; sampled on acceptance.
REQ-010 The block SHALL have port out_valid, output, 1 bit: data_out holds a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port data_out, output, 64 bits: the result.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-014 The FSM SHALL have states IDLE, KEYEXP, ROUND and DONE.
REQ-015 Encrypt: IDLE->ROUND on acceptance; ROUND performs rounds 1..NUM_ROUNDS one per cycle; the final add-key with K[NUM_ROUNDS+1] is applied on the last ROUND cycle; then ->DONE.
REQ-016 Encrypt latency SHALL be exactly NUM_ROUNDS+1 cycles from the acceptance edge to the edge setting out_valid.
REQ-017 Decrypt: IDLE->KEYEXP on acceptance, unless the key cache hits; KEYEXP runs the forward key schedule NUM_ROUNDS steps to obtain K[NUM_ROUNDS+1].
REQ-018 From KEYEXP the block SHALL enter ROUND, which applies the initial add-key of K[NUM_ROUNDS+1]; each later cycle does inverse P-layer, inverse S-layer, then add-key of K[i], with i descending NUM_ROUNDS..1, and the inverse key schedule runs in step.
REQ-019 The key cache SHALL hold the last user key and its expanded final key, plus a valid flag; a decrypt request whose key equals the cached key SHALL skip KEYEXP (IDLE->ROUND).
REQ-020 Decrypt latency SHALL be 2*NUM_ROUNDS+1 cycles on a cache miss and NUM_ROUNDS+1 on a hit.
REQ-021 Each completed KEYEXP SHALL update the cache; an encrypt request SHALL not alter the cache.
REQ-022 The key schedule for KEY_SIZE=80 SHALL be: rotate left 61, S-box on bits [79:76], XOR the 5-bit round counter into bits [19:15].
REQ-023 The key schedule for KEY_SIZE=128 SHALL be: rotate left 61, S-box on [127:124] and [123:120], XOR the counter into [66:62].
REQ-024 The inverse key schedule SHALL be the exact inverse of REQ-022/023, with the steps in reverse order.
REQ-025 The round key SHALL be the top 64 bits of the key register.
REQ-026 DONE SHALL assert out_valid and hold data_out stable until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-027 in_ready SHALL become 1 in the cycle after the handoff; there is no bypass, so back-to-back throughput is one request per latency+2 cycles.
REQ-028 in_valid and input changes while the block is busy SHALL be ignored.
REQ-029 The round counter SHALL be 5 bits wide; a static check SHALL require NUM_ROUNDS <= 31.

Reset
REQ-030 On a Clock edge with Reset=1, the block SHALL go to IDLE with in_ready=1, out_valid=0, data_out=0, counter=0 and cache valid=0.
REQ-031 Reset asserted mid-operation (KEYEXP, ROUND or DONE) SHALL abort the request, discard the result and invalidate the cache.

Structure
REQ-032 Package present_pkg SHALL hold the S-box and inverse S-box functions, the P-layer and inverse P-layer functions, the state_t enum, and the block size constant 64.
REQ-033 Sub-module present_key_sched SHALL hold the key register, with a forward/inverse step select and the KEY_SIZE parameter.

Verification
REQ-034 KEY_SIZE=80, key=0, encrypt data_in=0 -> data_out=5579C1387B228445, out_valid after exactly 32 cycles.
REQ-035 KEY_SIZE=80, key=all-F, encrypt data_in=all-F -> 3333DCD3213210D2; then decrypt 3333DCD3213210D2 with the same key -> all-F after 32 cycles (cache hit).
REQ-036 KEY_SIZE=80, key=0, decrypt 5579C1387B228445 from reset -> 0, latency 63 cycles; an immediate repeat -> latency 32.
REQ-037 KEY_SIZE=128, key=0, encrypt 0 -> 96DB702A2E6900AF; decrypt it back to 0.
REQ-038 Hold out_ready=0 for 10 cycles -> out_valid and data_out stable, in_ready=0; then assert out_ready -> in_ready=1 next cycle.
REQ-039 Assert Reset during cycle 20 of a decrypt -> next cycle IDLE, out_valid=0; the next decrypt of the same key misses the cache (63 cycles).
